// File: rtl/match_ctrl_pkg.sv
// match_ctrl_pkg: shared game encodings for the pong match controller.
// Holds state codes, winner codes, score width and the winner judge.
package match_ctrl_pkg;

   localparam int SCORE_W = 9;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_OVER      = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_L    = 2'b01,
      WIN_R    = 2'b10,
      WIN_DRAW = 2'b11
   } win_t;

   function automatic win_t judge(
      input logic [SCORE_W-1:0] l,
      input logic [SCORE_W-1:0] r
   );
      if (l > r)      return WIN_L;
      else if (r > l) return WIN_R;
      else            return WIN_DRAW;
   endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// match_ctrl_if: start/score inputs and status outputs of match_ctrl.
// master = driver side (start_p, scores); slave = match_ctrl.
interface match_ctrl_if;
   import match_ctrl_pkg::*;

   logic               start_p;
   logic [SCORE_W-1:0] l_score;
   logic [SCORE_W-1:0] r_score;
   logic               step_en;
   logic [2:0]         state;
   logic [2:0]         countdown;
   logic [7:0]         match_time;
   logic               game_over;
   logic [1:0]         winner;

   modport master (
      output start_p, l_score, r_score,
      input  step_en, state, countdown,
      input  match_time, game_over, winner
   );

   modport slave (
      input  start_p, l_score, r_score,
      output step_en, state, countdown,
      output match_time, game_over, winner
   );

endinterface

// File: rtl/match_ctrl_tick_div.sv
// tick_div: modulo-N counter with sync clear and enable.
// Ports: clk, clr (clear, wins), en (count), tc (pulse at N-1 while en).
module tick_div #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt;

   assign tc = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
   end

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: pong match flow FSM (idle/countdown/play/pause/over),
// physics step strobe, match clock and winner decision.
// Ports: clk, rst_n (sync, active-high), bus (match_ctrl_if.slave).
// Macro SCORE_LIMIT_EN: a score reaching WIN_SCORE ends play early.
module match_ctrl
   import match_ctrl_pkg::*;
#(
   parameter int                 FRAME_DIV  = 833333,
   parameter int                 SEC_DIV    = 100000000,
   parameter int                 MATCH_SECS = 180,
   parameter int                 COUNT_SECS = 3,
   parameter logic [SCORE_W-1:0] WIN_SCORE  = 9'd15
) (
   input logic        clk,
   input logic        rst_n,
   match_ctrl_if.slave bus
);

`ifdef SCORE_LIMIT_EN
   localparam bit LIMIT_ON = 1'b1;
`else
   localparam bit LIMIT_ON = 1'b0;
`endif

   localparam logic [2:0] CD_INIT = 3'(COUNT_SECS);
   localparam logic [7:0] MT_INIT = 8'(MATCH_SECS);

   state_t     state_q, state_n;
   logic [2:0] cd_q, cd_n;
   logic [7:0] mt_q, mt_n;
   logic       step_q;
   logic       over_q;
   win_t       win_q;

   logic sec_clr, frame_clr;
   logic sec_tc, frame_tc;
   logic score_hit;

   tick_div #(.N(SEC_DIV)) u_sec (
      .clk (clk),
      .clr (rst_n | sec_clr),
      .en  (state_q == ST_COUNTDOWN || state_q == ST_PLAY),
      .tc  (sec_tc)
   );

   tick_div #(.N(FRAME_DIV)) u_frame (
      .clk (clk),
      .clr (rst_n | frame_clr),
      .en  (state_q == ST_PLAY),
      .tc  (frame_tc)
   );

   assign score_hit = LIMIT_ON &&
      (bus.l_score >= WIN_SCORE || bus.r_score >= WIN_SCORE);

   always_comb begin
      state_n   = state_q;
      cd_n      = cd_q;
      mt_n      = mt_q;
      sec_clr   = 1'b0;
      frame_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cd_n    = CD_INIT;
            sec_clr = 1'b1;
            if (bus.start_p)
               state_n = ST_COUNTDOWN;
         end
         ST_COUNTDOWN: begin
            if (bus.start_p) begin
               state_n = ST_PAUSE;
            end else if (sec_tc) begin
               if (cd_q == 3'd1) begin
                  state_n   = ST_PLAY;
                  cd_n      = 3'd0;
                  sec_clr   = 1'b1;
                  frame_clr = 1'b1;
               end else if (cd_q != 3'd0) begin
                  cd_n = cd_q - 3'd1;
               end
            end
         end
         ST_PLAY: begin
            // expiry/score limit beats start_p; start_p beats bookkeeping
            if ((sec_tc && mt_q == 8'd1) || score_hit) begin
               state_n = ST_OVER;
               if (sec_tc && mt_q != 8'd0)
                  mt_n = mt_q - 8'd1;
            end else if (bus.start_p) begin
               state_n = ST_PAUSE;
            end else if (sec_tc && mt_q != 8'd0) begin
               mt_n = mt_q - 8'd1;
            end
         end
         ST_PAUSE: begin
            if (bus.start_p) begin
               state_n = ST_COUNTDOWN;
               cd_n    = CD_INIT;
               sec_clr = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= ST_IDLE;
         cd_q    <= CD_INIT;
         mt_q    <= MT_INIT;
         step_q  <= 1'b0;
         over_q  <= 1'b0;
         win_q   <= WIN_NONE;
      end else begin
         state_q <= state_n;
         cd_q    <= cd_n;
         mt_q    <= mt_n;
         // strobe only if play continues into the next cycle
         step_q  <= frame_tc && (state_n == ST_PLAY);
         over_q  <= (state_n == ST_OVER);
         if (state_n == ST_OVER && state_q != ST_OVER)
            win_q <= judge(bus.l_score, bus.r_score);
      end
   end

   assign bus.state      = state_q;
   assign bus.countdown  = cd_q;
   assign bus.match_time = mt_q;
   assign bus.step_en    = step_q;
   assign bus.game_over  = over_q;
   assign bus.winner     = win_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: scoreboard bench for match_ctrl with an elapsed-time
// reference model; directed scenarios followed by random start/reset.
module tb_match_ctrl;
   import match_ctrl_pkg::*;

   localparam int FD = 4;
   localparam int SD = 10;
   localparam int MS = 3;
   localparam int CS = 2;
   localparam logic [8:0] WS = 9'd5;
`ifdef SCORE_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   match_ctrl_if bus();

   match_ctrl #(
      .FRAME_DIV  (FD),
      .SEC_DIV    (SD),
      .MATCH_SECS (MS),
      .COUNT_SECS (CS),
      .WIN_SCORE  (WS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] cd;
      logic [7:0] mt;
      logic       stp;
      logic       go;
      logic [1:0] win;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   // model: phase + cycles elapsed in phase; outputs derived arithmetically
   int m_st = 0;
   int el = 0;
   int mt_base = MS;
   int cd_hold = 0;
   int mt_hold = 0;
   int mt_over = 0;
   int m_win = 0;

   function automatic exp_t model_out();
      exp_t e;
      e = '0;
      e.st = 3'(m_st);
      case (m_st)
         0: begin
            e.cd = 3'(CS);
            e.mt = 8'(MS);
         end
         1: begin
            e.cd = 3'(CS - el / SD);
            e.mt = 8'(mt_base);
         end
         2: begin
            e.mt  = 8'(mt_base - el / SD);
            e.stp = (el > 0) && (el % FD == 0);
         end
         3: begin
            e.cd = 3'(cd_hold);
            e.mt = 8'(mt_hold);
         end
         default: begin
            e.mt  = 8'(mt_over);
            e.go  = 1'b1;
            e.win = 2'(m_win);
         end
      endcase
      return e;
   endfunction

   task automatic model_step(input bit s, input int l, input int r,
                             input bit rst);
      exp_t cur;
      bit   tick;
      bit   hit;
      cur  = model_out();
      tick = ((el + 1) % SD == 0);
      hit  = LIM && (l >= int'(WS) || r >= int'(WS));
      if (rst) begin
         m_st = 0; el = 0; mt_base = MS; m_win = 0;
      end else begin
         case (m_st)
            0: if (s) begin
               m_st = 1; el = 0; mt_base = MS;
            end
            1: begin
               if (s) begin
                  m_st = 3; cd_hold = int'(cur.cd);
                  mt_hold = int'(cur.mt);
               end else if (tick && cur.cd == 3'd1) begin
                  m_st = 2; el = 0;
               end else el++;
            end
            2: begin
               if ((tick && cur.mt == 8'd1) || hit) begin
                  m_st = 4;
                  mt_over = tick ? int'(cur.mt) - 1 : int'(cur.mt);
                  m_win = (l > r) ? 1 : (r > l) ? 2 : 3;
               end else if (s) begin
                  m_st = 3; cd_hold = 0; mt_hold = int'(cur.mt);
               end else el++;
            end
            3: if (s) begin
               m_st = 1; el = 0; mt_base = mt_hold;
            end
            default: ;
         endcase
      end
      q.push_back(model_out());
   endtask

   task automatic cyc(input bit s, input bit rst);
      bus.start_p = s;
      rst_n = rst;
      @(posedge clk);
      model_step(s, int'(bus.l_score), int'(bus.r_score), rst);
      #1;
      bus.start_p = 1'b0;
      rst_n = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) cyc(1'b0, 1'b0);
   endtask

   task automatic run_until(input int st, input int lim);
      int n = 0;
      while (m_st != st && n < lim) begin
         cyc(1'b0, 1'b0);
         n++;
      end
      if (m_st != st) begin
         total++;
         bad++;
         $display("FAIL wait_state got=%0d want=%0d", m_st, st);
      end
   endtask

   exp_t g_m, e_m;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e_m = q.pop_front();
         g_m.st  = bus.state;
         g_m.cd  = bus.countdown;
         g_m.mt  = bus.match_time;
         g_m.stp = bus.step_en;
         g_m.go  = bus.game_over;
         g_m.win = bus.winner;
         total++;
         if (g_m !== e_m) begin
            bad++;
            $display({"FAIL outputs t=%0t got/want st=%0d/%0d cd=%0d/%0d",
                      " mt=%0d/%0d step=%0b/%0b go=%0b/%0b win=%0d/%0d"},
                     $time, g_m.st, e_m.st, g_m.cd, e_m.cd, g_m.mt,
                     e_m.mt, g_m.stp, e_m.stp, g_m.go, e_m.go,
                     g_m.win, e_m.win);
         end
      end
   end

   initial begin
      int n;
      bus.start_p = 1'b0;
      bus.l_score = '0;
      bus.r_score = '0;
      rst_n = 1'b1;

      // reset and idle
      repeat (3) cyc(1'b0, 1'b1);
      run(50);

      // full match, left wins, start ignored in OVER
      bus.l_score = 9'd2;
      bus.r_score = 9'd1;
      cyc(1'b1, 1'b0);
      run_until(4, 200);
      run(5);
      cyc(1'b1, 1'b0);
      run(20);

      // pause mid-play with match_time=2, then resume
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      run_until(2, 100);
      run(12);
      cyc(1'b1, 1'b0);
      run(100);
      cyc(1'b1, 1'b0);
      run_until(2, 100);
      run_until(4, 200);

      // back-to-back pulses, then reset in PAUSE
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      run_until(2, 100);
      run(5);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      run(3);
      cyc(1'b1, 1'b0);
      run(5);
      cyc(1'b0, 1'b1);
      run(3);

      // right score reaches limit in play, then reset in OVER
      bus.l_score = 9'd0;
      bus.r_score = 9'd0;
      cyc(1'b1, 1'b0);
      run_until(2, 100);
      run(6);
      bus.r_score = 9'd5;
      run(40);
      run_until(4, 100);
      cyc(1'b0, 1'b1);
      run(2);

      // start_p on the expiry tick: expiry wins, draw
      bus.l_score = 9'd1;
      bus.r_score = 9'd1;
      cyc(1'b1, 1'b0);
      run_until(2, 100);
      n = 0;
      while (!(m_st == 2 && (el + 1) % SD == 0 &&
               model_out().mt == 8'd1) && n < 100) begin
         cyc(1'b0, 1'b0);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL wait_expiry got=%0d want=2", m_st);
      end
      cyc(1'b1, 1'b0);
      run(3);

      // random start pulses, scores and resets
      cyc(1'b0, 1'b1);
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.l_score = 9'($urandom_range(0, 6));
            bus.r_score = 9'($urandom_range(0, 6));
         end
         cyc($urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
      end

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL queue_drain got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
